// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron layer.
package lif_pkg;

  typedef enum logic {
    IDLE,
    UPDATE
  } fsm_state_t;

  localparam int RESET_ZERO     = 0;
  localparam int RESET_SUBTRACT = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width that can hold values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_layer_if.sv
// Timestep handshake and neuron readout bundle for lif_layer.
interface lif_layer_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic           start;
  logic [N*W-1:0] current;
  logic [W-1:0]   thresh;
  logic           busy;
  logic           done;
  logic [N-1:0]   spike;
  logic [N*W-1:0] state;

  modport master (output start, current, thresh, input busy, done, spike, state);
  modport slave  (input start, current, thresh, output busy, done, spike, state);
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron step: leak, integrate, saturate, fire and refractory.
module lif_update import lif_pkg::*; #(
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2,
  parameter int RESET_SUB  = RESET_SUBTRACT,
  parameter int RW         = 2
) (
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  t,
  input  logic [RW-1:0] refr,
  output logic [W-1:0]  s_next,
  output logic [RW-1:0] refr_next,
  output logic          fire
);

  logic [W:0]   sum_wide;
  logic [W-1:0] sum_sat;

  // The leak term never exceeds s, so only the upper end can overflow.
  always_comb begin
    sum_wide  = {1'b0, s} - {1'b0, (s >> LEAK_SHIFT)} + {1'b0, c};
    sum_sat   = sum_wide[W] ? '1 : sum_wide[W-1:0];
    s_next    = s;
    refr_next = refr;
    fire      = 1'b0;
    if (refr != '0) begin
      refr_next = refr - 1'b1;
    end else if ((sum_sat >= t) && (t != '0)) begin
      fire      = 1'b1;
      refr_next = RW'(REFRACT);
      s_next    = (RESET_SUB == RESET_SUBTRACT) ? (sum_sat - t) : '0;
    end else begin
      s_next = sum_sat;
    end
  end

endmodule

// File: rtl/lif_layer.sv
// Layer of N LIF neurons sharing one update datapath, one channel per cycle per timestep.
module lif_layer import lif_pkg::*; #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2,
  parameter int RESET_SUB  = RESET_SUBTRACT
) (
  input  logic        clk,
  input  logic        rst,
  lif_layer_if.slave  bus
);

  localparam int IW = idx_width(N);
  localparam int RW = idx_width(REFRACT + 1);

  fsm_state_t state_q;
  fsm_state_t next_state;

  logic [IW-1:0]           idx_q;
  logic [N-1:0][W-1:0]     snap_cur;
  logic [W-1:0]            snap_thr;
  logic [N-1:0][W-1:0]     mem;
  logic [N-1:0][RW-1:0]    refr;
  logic [N-1:0]            spike_q;
  logic                    done_q;

  logic                    busy_c;
  logic                    accept;
  logic                    step;
  logic                    last;

  logic [W-1:0]            s_next;
  logic [RW-1:0]           refr_next;
  logic                    fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (bus.start) next_state = UPDATE;
      UPDATE:  if (idx_q == IW'(N - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state_q == UPDATE);
    accept = (state_q == IDLE) && bus.start;
    step   = (state_q == UPDATE);
    last   = step && (idx_q == IW'(N - 1));
  end

  lif_update #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT),
    .RESET_SUB  (RESET_SUB),
    .RW         (RW)
  ) u_update (
    .s         (mem[idx_q]),
    .c         (snap_cur[idx_q]),
    .t         (snap_thr),
    .refr      (refr[idx_q]),
    .s_next    (s_next),
    .refr_next (refr_next),
    .fire      (fire)
  );

  // Inputs are frozen at accept so the running timestep ignores later changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      snap_cur <= '0;
      snap_thr <= '0;
      mem      <= '0;
      refr     <= '0;
      spike_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        snap_cur <= bus.current;
        snap_thr <= bus.thresh;
        spike_q  <= '0;
        idx_q    <= '0;
      end else if (step) begin
        mem[idx_q]     <= s_next;
        refr[idx_q]    <= refr_next;
        spike_q[idx_q] <= fire;
        idx_q          <= idx_q + 1'b1;
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_q;
  assign bus.spike = spike_q;
  assign bus.state = mem;

endmodule

// File: doc/lif_layer.md
Name: lif_layer

Overview:
- Layer of N leaky integrate-and-fire neurons that share one time-multiplexed update datapath.
- Each `start` strobe is one timestep: all input currents are snapshotted, then the neurons are updated one per cycle.
- The block adds per-channel refractory periods, a selectable post-spike reset mode and saturating arithmetic.
- Sits between the input-current source and the spike/state readout logic; runtime threshold comes from a config register.

Parameters:
- N, 4, number of neurons (channels), >=1.
- W, 8, membrane-state and current width in bits.
- LEAK_SHIFT, 3, leak per step = state >> LEAK_SHIFT; 0 means no leak.
- REFRACT, 2, refractory timesteps after a spike; 0 disables refractory.
- RESET_SUB, 1, 1 = subtract threshold on spike, 0 = reset state to zero.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one timestep; accepted only when busy=0.
- current  in  N*W  per-channel input current, channel i at [i*W +: W].
- thresh  in  W  firing threshold; sampled at start.
- busy  out  1  high while channels are being updated.
- done  out  1  one-cycle pulse when the timestep completes.
- spike  out  N  per-channel spike flags for the last completed timestep.
- state  out  N*W  per-channel membrane state.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset, on a rst=1 at a clk edge:
  - state, spike, refractory counters, busy, done and the channel index all go to 0.
  - FSM goes to IDLE.
  - Reset mid-timestep aborts it; no done pulse is produced.
- FSM states: IDLE and UPDATE.
- IDLE:
  - start=1 latches current[] and thresh into snapshot registers.
  - Clears the spike vector, sets idx=0, busy=1, and moves to UPDATE.
- UPDATE:
  - Each cycle processes channel idx and increments idx.
  - When idx=N-1 is processed: next cycle busy=0 and done=1 for exactly one cycle, FSM returns to IDLE.
- start while busy=1 is ignored: no queuing, snapshot unchanged.
- Latency: done asserts N+1 cycles after the start edge. spike and state are stable from done until the next accepted start.
- Per-channel update, where s = state, c = snapshot current, T = snapshot thresh:
  - If refr>0: s is held, refr decrements, spike=0 and the input is ignored.
  - Else compute sum = s - (s >> LEAK_SHIFT) + c in W+1 bits, then saturate to 2^W-1.
    - If sum >= T and T != 0: spike=1, refr=REFRACT, and s = RESET_SUB ? sum - T : 0.
    - Otherwise s = sum and spike=0.
  - T=0 disables firing; the state simply saturates.
- Channels not currently indexed hold their state.
- Because current is snapshotted at start, later input changes do not affect the running timestep.

Decomposition:
- Package lif_pkg holds:
  - FSM state enum (IDLE, UPDATE);
  - reset-mode constants RESET_ZERO and RESET_SUBTRACT;
  - index-width function clog2(N).
- Sub-module lif_update: purely combinational single-neuron update.
  - Inputs: s, c, T, refr.
  - Outputs: s_next, refr_next, fire.
  - Parametrised by W, LEAK_SHIFT, REFRACT, RESET_SUB.
- lif_layer owns the FSM, the snapshot registers and the state/refractory arrays.

Test Plan:
All scenarios use the defaults (N=4, W=8, LEAK_SHIFT=3, REFRACT=2, RESET_SUB=1) with thresh=100 unless stated.
- Reset: assert rst for 2 cycles -> state=0, spike=0, busy=0, done=0.
- Integration and fire, ch0 current=50, others 0, repeated timesteps:
  - step1 state0=50; step2 state0=94;
  - step3 spike[0]=1, state0=33;
  - steps 4–5 state0 held at 33 with spike=0;
  - step6 state0=79.
- Same current with RESET_SUB=0 -> step3 gives state0=0 and spike[0]=1.
- Saturation: thresh=255, ch1 preloaded to 200, current=255 -> sum 430 saturates to 255, spike[1]=1, state1=0.
- Handshake:
  - start pulses at t0 and t0+2 -> only one timestep runs;
  - done high only at t0+5 (N+1), busy high t0+1..t0+4;
  - current changed at t0+1 has no effect.
- Reset mid-timestep:
  - rst at t0+2 -> no done pulse, all state=0, FSM in IDLE;
  - next start runs normally.
